// File: rtl/fp_square_iter.sv
// ============================================================================
// Module   : fp_square_iter
// Function : IEEE-754 single/double squarer with a shift-add mantissa multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_square_iter #(
    parameter logic [10:0] DOUBLE_BIAS   = 11'd1023,
    parameter logic [7:0]  SINGLE_BIAS   = 8'd127,
    parameter logic [3:0]  EXPONENT_SIZE = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isFloat,
    input  logic        start,
    input  logic [63:0] in,
    output logic [63:0] out,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow
);

    localparam int ES = int'(EXPONENT_SIZE);
    localparam int EW = ES + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q;
    logic           isf_q;
    logic [ES-1:0]  exp_q;
    logic [105:0]   mcand_q;
    logic [52:0]    mplier_q;
    logic [105:0]   acc_q;
    logic [5:0]     cnt_q;
    logic [63:0]    out_q;
    logic           done_q;
    logic           ovf_q;
    logic           unf_q;

    // Normalization of the finished product
    logic           prod_hi_d;
    logic [22:0]    frac_s_d;
    logic [51:0]    frac_d_d;
    logic [EW-1:0]  bias_d;
    logic [EW-1:0]  exp_d;
    logic           ovf_d;
    logic           unf_d;
    logic [63:0]    res_d;

    always_comb begin
        prod_hi_d = isf_q ? acc_q[47] : acc_q[105];
        frac_s_d  = acc_q[47]  ? acc_q[46:24]  : acc_q[45:23];
        frac_d_d  = acc_q[105] ? acc_q[104:53] : acc_q[103:52];
        bias_d    = isf_q ? EW'(SINGLE_BIAS) : EW'(DOUBLE_BIAS);
        exp_d     = EW'({exp_q, 1'b0}) - bias_d + EW'(prod_hi_d);
        unf_d     = exp_d[EW-1] | (exp_d == '0);
        ovf_d     = !unf_d && (exp_d >= (isf_q ? EW'(255) : EW'(2047)));
        if (unf_d)
            res_d = 64'd0;
        else if (ovf_d)
            res_d = isf_q ? {32'd0, 32'h7F80_0000} : 64'h7FF0_0000_0000_0000;
        else if (isf_q)
            res_d = {32'd0, 1'b0, exp_d[7:0], frac_s_d};
        else
            res_d = {1'b0, exp_d[10:0], frac_d_d};
    end

    // Special-operand decode on the raw input; the sign bit never matters
    logic           in_exp_ones;
    logic           in_exp_zero;
    logic           in_frac_nz;
    logic           in_special;
    logic [63:0]    spec_res;
    logic           unused_sign;

    assign unused_sign = in[63];

    always_comb begin
        in_exp_ones = isFloat ? (&in[30:23]) : (&in[62:52]);
        in_exp_zero = isFloat ? ~(|in[30:23]) : ~(|in[62:52]);
        in_frac_nz  = isFloat ? (|in[22:0]) : (|in[51:0]);
        in_special  = in_exp_ones | in_exp_zero;
        if (in_exp_zero)
            spec_res = 64'd0;
        else if (in_frac_nz)
            spec_res = isFloat ? {32'd0, 32'h7FC0_0000} : 64'h7FF8_0000_0000_0000;
        else
            spec_res = isFloat ? {32'd0, 32'h7F80_0000} : 64'h7FF0_0000_0000_0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            isf_q    <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        isf_q <= isFloat;
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                        if (in_special) begin
                            out_q   <= spec_res;
                            state_q <= S_DONE;
                        end else begin
                            exp_q    <= isFloat ? ES'(in[30:23]) : ES'(in[62:52]);
                            mcand_q  <= isFloat ? 106'({1'b1, in[22:0]}) : 106'({1'b1, in[51:0]});
                            mplier_q <= isFloat ? 53'({1'b1, in[22:0]})  : {1'b1, in[51:0]};
                            acc_q    <= '0;
                            cnt_q    <= isFloat ? 6'd24 : 6'd53;
                            state_q  <= S_MULT;
                        end
                    end
                end
                S_MULT: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1)
                        state_q <= S_NORM;
                end
                S_NORM: begin
                    out_q   <= res_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    state_q <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

`default_nettype wire

// File: doc/fp_square_iter.md
FP_SQUARE_ITER -- requirements
Module: fp_square_iter

Interface
REQ-001 SHALL have parameter DOUBLE_BIAS, default 11'd1023, double-precision exponent bias.
REQ-002 SHALL have parameter SINGLE_BIAS, default 8'd127, single-precision exponent bias.
REQ-003 SHALL have parameter EXPONENT_SIZE, default 4'd11, internal exponent width excluding guard bits.
REQ-004 SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have isFloat  input  1  1 = single precision (in[31:0]), 0 = double (in[63:0]); sampled with start.
REQ-007 SHALL have start  input  1  request; accepted only in IDLE.
REQ-008 SHALL have in  input  64  IEEE-754 operand.
REQ-009 SHALL have out  output  64  IEEE-754 result x*x; single result in out[31:0], out[63:32] = 0.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.
REQ-011 SHALL have done  output  1  one-cycle pulse; out and flags valid from that cycle.
REQ-012 SHALL have overflow  output  1  result saturated to +inf.
REQ-013 SHALL have underflow  output  1  result flushed to +0.

Function
REQ-014 SHALL implement states IDLE, MULT, NORM, DONE.
REQ-015 SHALL, on start high in IDLE, latch isFloat, sign-stripped exponent, and mantissa with hidden 1 (24 bits single, 53 bits double).
REQ-016 SHALL compute the mantissa product by shift-add, one multiplier bit per cycle: N = 24 (single) or 53 (double) cycles in MULT.
REQ-017 SHALL go MULT -> NORM after N cycles, NORM -> DONE, DONE -> IDLE unconditionally.
REQ-018 SHALL, for normal operands, assert done for exactly the cycle following rising edge T0+N+2, where T0 is the edge that sampled start.
REQ-019 SHALL compute result exponent = 2*e - bias, plus 1 when product >= 2.0 (product shifted right one place), in a signed width of EXPONENT_SIZE+2 bits.
REQ-020 SHALL truncate the normalized product to 23/52 fraction bits (round toward zero).
REQ-021 SHALL force sign bit 0 for every result, including negative inputs.
REQ-022 SHALL, if result exponent >= 255 (single) / 2047 (double), output +inf and set overflow.
REQ-023 SHALL, if result exponent <= 0, output +0 and set underflow.
REQ-024 SHALL treat special inputs without MULT/NORM (IDLE -> DONE, done after edge T0+1): zero or denormal -> +0 (no flag); inf -> +inf (no flag); NaN -> quiet NaN 0x7FC00000 / 0x7FF8000000000000.
REQ-025 SHALL ignore start while busy; in and isFloat changes during busy SHALL not affect the result.
REQ-026 SHALL hold out, overflow, underflow stable from done until the edge that accepts the next start, which clears both flags.
REQ-027 SHALL accept start in the cycle done is high only after returning to IDLE (earliest acceptance one cycle after done).

Reset
REQ-028 SHALL, while rst high at a rising edge, force IDLE, out = 0, busy = 0, done = 0, overflow = 0, underflow = 0, regardless of state.
REQ-029 SHALL discard any in-progress operation on reset; no done pulse for it afterwards.

Verification
REQ-030 SHALL check single 0x40000000 (2.0) -> out 0x0000000040800000, done after edge T0+26, flags 0.
REQ-031 SHALL check single 0x3FC00000 (1.5) -> 0x40100000 (2.25, normalize path) and single 0xC0000000 (-2.0) -> 0x40800000.
REQ-032 SHALL check double 0x4008000000000000 (3.0) -> 0x4022000000000000 (9.0), done after edge T0+55.
REQ-033 SHALL check single 0x7F000000 -> 0x7F800000 with overflow = 1; double 0x1A70000000000000 (2^-600) -> 0 with underflow = 1.
REQ-034 SHALL check special inputs: single 0x00000000 -> 0, 0xFF800000 -> 0x7F800000, 0x7FC00001 -> 0x7FC00000, each done after edge T0+1.
REQ-035 SHALL check rst asserted for one cycle at T0+10 of a double operation -> all outputs 0, no done; next start with 2.0 single completes normally; start pulses during busy ignored.
